switch_debouncer: RTL and testbench

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/switch_debouncer.sv | 76 +++++++
 tb/tb_switch_debouncer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer: four independent 2-flop synchronized, counter-based switch debouncers
// Ports: clk/rst (sync, active-high); RawIn[3:0] raw switches {Sw1,Sw2,Sw3,Sa};
//        Sw1/Sw2/Sw3/Sa debounced levels; EdgeRise/EdgeFall one-cycle accept pulses; Changed = OR of pulses
module switch_debouncer #(
    parameter logic [15:0] CNT_MAX = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] RawIn,
    output logic       Sw1,
    output logic       Sw2,
    output logic       Sw3,
    output logic       Sa,
    output logic [3:0] EdgeRise,
    output logic [3:0] EdgeFall,
    output logic       Changed
);
    typedef enum logic {STABLE, PENDING} state_t;
    logic [3:0]  meta, sync, db, db_n, rise_n, fall_n;
    state_t      state [4];
    state_t      state_n [4];
    logic [15:0] cnt [4];
    logic [15:0] cnt_n [4];
    assign {Sw1, Sw2, Sw3, Sa} = db;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta     <= '0;
            sync     <= '0;
            db       <= '0;
            EdgeRise <= '0;
            EdgeFall <= '0;
            Changed  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                state[i] <= STABLE;
                cnt[i]   <= '0;
            end
        end else begin
            meta     <= RawIn;
            sync     <= meta;
            db       <= db_n;
            EdgeRise <= rise_n;
            EdgeFall <= fall_n;
            Changed  <= |(rise_n | fall_n);
            for (int i = 0; i < 4; i++) begin
                state[i] <= state_n[i];
                cnt[i]   <= cnt_n[i];
            end
        end
    end
    // The counter holds how many consecutive differing samples have been seen;
    // reaching CNT_MAX-1 while still differing means this is the CNT_MAX-th one.
    always_comb begin
        db_n   = db;
        rise_n = '0;
        fall_n = '0;
        for (int i = 0; i < 4; i++) begin
            state_n[i] = state[i];
            cnt_n[i]   = cnt[i];
            if (state[i] == STABLE) begin
                state_n[i] = (sync[i] != db[i]) ? PENDING : STABLE;
                cnt_n[i]   = (sync[i] != db[i]) ? 16'd1 : 16'd0;
            end else if (sync[i] == db[i]) begin
                state_n[i] = STABLE;
                cnt_n[i]   = '0;
            end else if (cnt[i] == CNT_MAX - 16'd1) begin
                state_n[i] = STABLE;
                cnt_n[i]   = '0;
                db_n[i]    = sync[i];
                rise_n[i]  = sync[i];
                fall_n[i]  = ~sync[i];
            end else begin
                cnt_n[i] = cnt[i] + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed and random checks of switch_debouncer against a sample-window model
module tb_switch_debouncer;
    localparam int CM = 4;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] raw, raw2;
    logic       sw1, sw2, sw3, sa;
    logic [3:0] rise, fall;
    logic       chg;
    logic       b_sw1, b_sw2, b_sw3, b_sa;
    logic [3:0] b_rise, b_fall;
    logic       b_chg;
    int         n_assert = 0;
    int         n_fail = 0;
    // Model: what the debounce logic examined each edge since reset, plus the
    // raw values sampled each edge (needed because of the two-edge sync delay).
    logic [3:0] raw_hist[$];
    logic [3:0] seen[$];
    logic [3:0] m_out, m_rise, m_fall;
    logic       m_chg;

    always #5 clk = ~clk;

    switch_debouncer #(.CNT_MAX(16'd4)) dut (
        .clk(clk), .rst(rst), .RawIn(raw),
        .Sw1(sw1), .Sw2(sw2), .Sw3(sw3), .Sa(sa),
        .EdgeRise(rise), .EdgeFall(fall), .Changed(chg)
    );

    switch_debouncer #(.CNT_MAX(16'd65535)) dut_big (
        .clk(clk), .rst(rst), .RawIn(raw2),
        .Sw1(b_sw1), .Sw2(b_sw2), .Sw3(b_sw3), .Sa(b_sa),
        .EdgeRise(b_rise), .EdgeFall(b_fall), .Changed(b_chg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // A channel accepts a new level when its last CM examined samples all
    // disagree with the current output.
    task automatic model_edge();
        logic [3:0] v;
        logic       all;
        if (rst) begin
            raw_hist.delete();
            seen.delete();
            m_out = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
        end else begin
            v = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size() - 2] : 4'b0;
            seen.push_back(v);
            raw_hist.push_back(raw);
            if (raw_hist.size() > 2) void'(raw_hist.pop_front());
            if (seen.size() > CM) void'(seen.pop_front());
            m_rise = '0;
            m_fall = '0;
            for (int b = 0; b < 4; b++) begin
                all = (seen.size() == CM);
                for (int k = 0; k < seen.size(); k++) begin
                    v = seen[k];
                    if (v[b] == m_out[b]) all = 1'b0;
                end
                if (all) begin
                    m_out[b]  = ~m_out[b];
                    m_rise[b] = m_out[b];
                    m_fall[b] = ~m_out[b];
                end
            end
            m_chg = |(m_rise | m_fall);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("out", {28'd0, sw1, sw2, sw3, sa}, {28'd0, m_out});
        chk("rise", {28'd0, rise}, {28'd0, m_rise});
        chk("fall", {28'd0, fall}, {28'd0, m_fall});
        chk("chg", {31'd0, chg}, {31'd0, m_chg});
        chk("exclusive", {28'd0, rise & fall}, 32'd0);
        chk("big_out", {27'd0, b_sw1, b_sw2, b_sw3, b_sa, b_chg}, 32'd0);
    endtask

    task automatic settle(input logic [3:0] v, input int n);
        raw = v;
        repeat (n) tick();
    endtask

    initial begin
        int lat, pulses, chg_cnt, hold;
        logic [3:0] acc;
        rst = 1'b1; raw = '0; raw2 = '0;
        tick(); tick();
        rst = 1'b0;
        settle(4'b0000, 20);
        // clean rise on Sw1: accepted on the 6th edge counted from the first sampling edge
        raw = 4'b1000; lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (sw1 && lat == 0) begin
                lat = k;
                chk("sw1_rise_pulse", {28'd0, rise}, 32'h8);
            end
        end
        chk("sw1_latency", lat, 6);
        settle(4'b0000, 12);
        // bouncing Sa: 2-cycle levels never accepted, final steady 1 accepted once
        for (int i = 0; i < 15; i++) settle({3'b000, i[0]}, 2);
        chk("sa_during_bounce", {31'd0, sa}, 32'd0);
        raw = 4'b0001; lat = 0; pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (rise[0]) pulses++;
            if (sa && lat == 0) lat = k;
        end
        chk("sa_latency", lat, 6);
        chk("sa_pulses", pulses, 1);
        settle(4'b0000, 12);
        // all four at once, then partial fall
        raw = 4'b1111; acc = '0; chg_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            acc |= rise;
            if (chg) begin
                chg_cnt++;
                chk("all_rise_together", {28'd0, rise}, 32'hf);
            end
        end
        chk("all_rise_acc", {28'd0, acc}, 32'hf);
        chk("all_rise_chg_cycles", chg_cnt, 1);
        raw = 4'b0101; acc = '0; chg_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            acc |= fall;
            if (chg) chg_cnt++;
        end
        chk("fall_1010", {28'd0, acc}, 32'ha);
        chk("fall_chg_cycles", chg_cnt, 1);
        chk("after_fall_out", {28'd0, sw1, sw2, sw3, sa}, 32'h5);
        settle(4'b0000, 12);
        // reset in the middle of a pending Sw2 change
        raw = 4'b0100;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("sw2_in_reset", {31'd0, sw2}, 32'd0);
        rst = 1'b0; lat = 0; pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (rise[2]) pulses++;
            if (sw2 && lat == 0) lat = k;
        end
        chk("sw2_after_reset_latency", lat, 6);
        chk("sw2_after_reset_pulses", pulses, 1);
        // 3-cycle glitch on the large-count instance
        raw2 = 4'b0010;
        repeat (3) tick();
        raw2 = 4'b0000;
        repeat (10) tick();
        chk("big_sw3", {31'd0, b_sw3}, 32'd0);
        // random hold lengths straddle the acceptance threshold, with occasional resets
        for (int i = 0; i < 150; i++) begin
            raw = 4'($urandom);
            hold = $urandom_range(1, 7);
            rst = ($urandom_range(0, 29) == 0);
            tick();
            rst = 1'b0;
            repeat (hold - 1) tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
